// File: rtl/mux_stage_pkg.sv
// -----------------------------------------------------------------------------
// mux_stage_pkg
// Shared types and helpers for the mux_stage selector/skid-buffer slice.
//   state_t      : occupancy state of the two-entry skid stage
//   sel_width()  : select width for a given source count
//   entry_width(): packed width of one stored entry (data + sel + bad_sel)
// -----------------------------------------------------------------------------
package mux_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // no entries held
      ST_FULL  = 2'd1,   // main register holds the head entry
      ST_SKID  = 2'd2    // main + skid both hold entries
   } state_t;

   // Width of a select index for num_src sources.
   function automatic int sel_width(input int num_src);
      return (num_src < 2) ? 1 : $clog2(num_src);
   endfunction

   // One stored entry: selected data, captured sel, bad_sel flag.
   function automatic int entry_width(input int width, input int sel_w);
      return width + sel_w + 1;
   endfunction

endpackage

// File: rtl/mux_stage_mux_n.sv
// -----------------------------------------------------------------------------
// mux_n
// Purely combinational NUM_SRC-way selector. An out-of-range select yields
// all-zero data and raises bad_sel.
//   src_flat : NUM_SRC sources, source k at [k*WIDTH +: WIDTH]
//   sel      : source index
//   data     : selected source (zero when sel >= NUM_SRC)
//   bad_sel  : 1 when sel >= NUM_SRC
// -----------------------------------------------------------------------------
module mux_n
   import mux_stage_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = sel_width(NUM_SRC)
) (
   input  logic [NUM_SRC*WIDTH-1:0] src_flat,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         data,
   output logic                     bad_sel
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs (no latch);
      // they are also the out-of-range result.
      data    = '0;
      bad_sel = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            data    = src_flat[k*WIDTH +: WIDTH];
            bad_sel = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_stage.sv
// -----------------------------------------------------------------------------
// mux_stage
// N-way selector feeding a two-entry valid/ready skid-buffered register stage.
// in_ready and out_valid are decoded from the registered state only, so there
// is no combinational path from out_ready to in_ready or from in_* to out_*.
//   clk, reset              : rising-edge clock, async active-high reset
//   src_flat, sel, in_valid : upstream sources, select and valid
//   in_ready                : stage can accept this cycle
//   flush                   : synchronous discard of all held entries
//   out_valid, out_data,
//   out_sel, out_bad_sel    : head entry
//   out_ready               : downstream consumes head entry
// -----------------------------------------------------------------------------
module mux_stage
   import mux_stage_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = sel_width(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] src_flat,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     out_bad_sel,
   input  logic                     out_ready
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             bad;
   } entry_t;

   state_t state;
   entry_t main_q;
   entry_t skid_q;
   entry_t new_entry;
   logic   accept;
   logic   consume;

   mux_n #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_mux (
      .src_flat (src_flat),
      .sel      (sel),
      .data     (new_entry.data),
      .bad_sel  (new_entry.bad)
   );

   assign new_entry.sel = sel;

   assign in_ready  = (state != ST_SKID);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   assign out_data    = main_q.data;
   assign out_sel     = main_q.sel;
   assign out_bad_sel = main_q.bad;

   // NOTE: state and data registers use non-blocking assignments so every
   // register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_EMPTY;
         // NOTE: the data registers are reset too: out_data must read zero
         // immediately on reset, not merely be marked invalid.
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         // Drop everything; data registers keep stale contents, now invalid.
         state <= ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_q <= new_entry;
                  state  <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (accept && consume) begin
                  main_q <= new_entry;
               end else if (accept) begin
                  skid_q <= new_entry;
                  state  <= ST_SKID;
               end else if (consume) begin
                  state <= ST_EMPTY;
               end
            end
            ST_SKID: begin
               // in_ready is low here, so only the consume side can move.
               if (consume) begin
                  main_q <= skid_q;
                  state  <= ST_FULL;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_stage.sv
// -----------------------------------------------------------------------------
// tb_mux_stage
// Directed, table-driven bench for mux_stage (NUM_SRC=4) plus a NUM_SRC=5
// instance for out-of-range selects. Outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_mux_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         out_ready;

   // NUM_SRC=4 instance
   logic [127:0] src_flat;
   logic [1:0]   sel;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;
   logic         out_bad_sel;

   // NUM_SRC=5 instance
   logic [159:0] src5;
   logic [2:0]   sel5;
   logic         in_valid5;
   logic         in_ready5;
   logic         out_valid5;
   logic [31:0]  out_data5;
   logic [2:0]   out_sel5;
   logic         out_bad_sel5;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux_stage #(.WIDTH(32), .NUM_SRC(4)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .src_flat    (src_flat),
      .sel         (sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_sel     (out_sel),
      .out_bad_sel (out_bad_sel),
      .out_ready   (out_ready)
   );

   mux_stage #(.WIDTH(32), .NUM_SRC(5)) u_dut5 (
      .clk         (clk),
      .reset       (reset),
      .src_flat    (src5),
      .sel         (sel5),
      .in_valid    (in_valid5),
      .in_ready    (in_ready5),
      .flush       (flush),
      .out_valid   (out_valid5),
      .out_data    (out_data5),
      .out_sel     (out_sel5),
      .out_bad_sel (out_bad_sel5),
      .out_ready   (out_ready)
   );

   typedef struct packed {
      logic        in_valid;
      logic [1:0]  sel;
      logic [31:0] val;
      logic        out_ready;
      logic        flush;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_data;
      logic [1:0]  e_sel;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Put val on the selected source; other sources carry distractors that
   // also change with val, so a held entry must not follow the inputs.
   task automatic drive4(input logic v, input logic [1:0] s, input logic [31:0] val);
      in_valid = v;
      sel      = s;
      for (int k = 0; k < 4; k++)
         src_flat[k*32 +: 32] = (k == int'(s)) ? val : ((32'hA5A5_0000 | k) ^ val);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            iv    sel   val            or    fl    e_ov  e_ir  e_data         e_sel
      vecs[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd2};
      vecs[1]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
      // back-pressure into SKID, then drain in order
      vecs[2]  = '{1'b1, 2'd0, 32'h11,       1'b0, 1'b0, 1'b1, 1'b1, 32'h11,       2'd0};
      vecs[3]  = '{1'b1, 2'd1, 32'h22,       1'b0, 1'b0, 1'b1, 1'b0, 32'h11,       2'd0};
      vecs[4]  = '{1'b1, 2'd3, 32'h33,       1'b0, 1'b0, 1'b1, 1'b0, 32'h11,       2'd0};
      vecs[5]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       2'd1};
      vecs[6]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
      // flush while in SKID with in_valid high
      vecs[7]  = '{1'b1, 2'd0, 32'h44,       1'b0, 1'b0, 1'b1, 1'b1, 32'h44,       2'd0};
      vecs[8]  = '{1'b1, 2'd1, 32'h55,       1'b0, 1'b0, 1'b1, 1'b0, 32'h44,       2'd0};
      vecs[9]  = '{1'b1, 2'd2, 32'h66,       1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        2'd0};
      vecs[10] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
      // flush with accept and consume in FULL: both ignored
      vecs[11] = '{1'b1, 2'd3, 32'h77,       1'b0, 1'b0, 1'b1, 1'b1, 32'h77,       2'd3};
      vecs[12] = '{1'b1, 2'd0, 32'h88,       1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        2'd0};
      vecs[13] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};
      // accept and consume together in FULL
      vecs[14] = '{1'b1, 2'd1, 32'h99,       1'b1, 1'b0, 1'b1, 1'b1, 32'h99,       2'd1};
      vecs[15] = '{1'b1, 2'd2, 32'hAA,       1'b1, 1'b0, 1'b1, 1'b1, 32'hAA,       2'd2};
      vecs[16] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        2'd0};

      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive4(1'b0, 2'd0, 32'h0);
      src5      = '0;
      sel5      = '0;
      in_valid5 = 1'b0;

      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_in_ready",  32'(in_ready),  32'd1);
      check("reset_out_data",  out_data,       32'h0);
      tick();
      tick();
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < NVEC; i++) begin
         drive4(vecs[i].in_valid, vecs[i].sel, vecs[i].val);
         out_ready = vecs[i].out_ready;
         flush     = vecs[i].flush;
         tick();
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
         if (vecs[i].e_ov) begin
            check($sformatf("v%0d_out_data", i), out_data,         vecs[i].e_data);
            check($sformatf("v%0d_out_sel", i),  32'(out_sel),     32'(vecs[i].e_sel));
            check($sformatf("v%0d_bad_sel", i),  32'(out_bad_sel), 32'd0);
         end
      end
      flush = 1'b0;

      // Streaming: 8 back-to-back entries, one out per cycle, in order
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive4(1'b1, 2'(i % 4), 32'h1000 + 32'(i));
         tick();
         check($sformatf("stream%0d_data", i),  out_data,       32'h1000 + 32'(i));
         check($sformatf("stream%0d_sel", i),   32'(out_sel),   32'(i % 4));
         check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("stream%0d_ready", i), 32'(in_ready),  32'd1);
      end
      drive4(1'b0, 2'd0, 32'h0);
      tick();
      check("stream_drain_valid", 32'(out_valid), 32'd0);

      // Out-of-range and last legal select on the NUM_SRC=5 instance
      for (int k = 0; k < 5; k++) src5[k*32 +: 32] = 32'hB000_0000 + 32'(k);
      in_valid5 = 1'b1;
      sel5      = 3'd6;
      tick();
      check("oor_out_valid", 32'(out_valid5),   32'd1);
      check("oor_out_data",  out_data5,         32'h0);
      check("oor_bad_sel",   32'(out_bad_sel5), 32'd1);
      check("oor_out_sel",   32'(out_sel5),     32'd6);
      sel5 = 3'd4;
      tick();
      check("sel4_out_data", out_data5,         32'hB000_0004);
      check("sel4_bad_sel",  32'(out_bad_sel5), 32'd0);
      in_valid5 = 1'b0;
      tick();
      check("n5_drain_valid", 32'(out_valid5), 32'd0);

      // Asynchronous reset mid-cycle while FULL
      out_ready = 1'b0;
      drive4(1'b1, 2'd1, 32'hCAFE_F00D);
      tick();
      drive4(1'b0, 2'd0, 32'h0);
      check("pre_areset_valid", 32'(out_valid), 32'd1);
      check("pre_areset_data",  out_data,       32'hCAFE_F00D);
      #2;
      reset = 1'b1;
      #1;
      check("areset_out_valid", 32'(out_valid), 32'd0);
      check("areset_out_data",  out_data,       32'h0);
      check("areset_out_sel",   32'(out_sel),   32'd0);
      check("areset_in_ready",  32'(in_ready),  32'd1);
      tick();
      reset = 1'b0;

      // First transfer after reset release
      out_ready = 1'b1;
      drive4(1'b1, 2'd2, 32'hDEADBEEF);
      tick();
      drive4(1'b0, 2'd0, 32'h0);
      check("post_reset_valid", 32'(out_valid),   32'd1);
      check("post_reset_data",  out_data,         32'hDEADBEEF);
      check("post_reset_sel",   32'(out_sel),     32'd2);
      check("post_reset_bad",   32'(out_bad_sel), 32'd0);
      tick();
      check("post_reset_drain", 32'(out_valid),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
